// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//
// Multi-cycle unsigned shift-and-add multiplier. One WIDTH-bit add per clock,
// WIDTH iterations per product, under a start/busy/done handshake.
//
// Ports:
//   clk_i    : single clock, all state updates on the rising edge
//   rst_i    : synchronous reset, active-high; overrides everything
//   start_i  : begin a multiply; only honoured in IDLE
//   bus_a_i  : multiplicand, unsigned, WIDTH bits (latched on start)
//   bus_b_i  : multiplier, unsigned, WIDTH bits (latched on start)
//   bus_o    : product register {acc_hi, acc_lo}, 2*WIDTH bits; valid with
//              done_o and held through IDLE, intermediate during RUN
//   busy_o   : high while iterating (RUN)
//   done_o   : one-cycle pulse when the product is complete (DONE)
//   flag_z_o : high when bus_o is zero
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   bus_a_i,
   input  logic [WIDTH-1:0]   bus_b_i,
   output logic [2*WIDTH-1:0] bus_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               flag_z_o
);

   // WIDTH >= 2 guarantees at least one count bit.
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;

   // Adder stage: the multiplicand is gated by the current multiplier LSB.
   // The extra top bit is the carry-out, which becomes the MSB of the shifted
   // accumulator so no product bit is lost.
   always_comb begin
      addend = acc_lo[0] ? mcand : '0;
      sum    = {1'b0, acc_hi} + {1'b0, addend};
   end

   // NOTE: every register here is written with <= so all updates use the
   // values from before the edge; blocking writes would let later statements
   // see half-updated state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         count  <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  mcand  <= bus_a_i;
                  acc_lo <= bus_b_i;
                  acc_hi <= '0;
                  count  <= '0;
                  state  <= RUN;
                  busy_o <= 1'b1;
               end
            end
            RUN: begin
               // Logical shift right of {carry, sum, acc_lo}; the consumed
               // multiplier bit drops off the bottom.
               {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
               count <= count + 1'b1;
               if (count == LAST) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

   assign bus_o    = {acc_hi, acc_lo};
   assign flag_z_o = (bus_o == '0);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Scoreboard bench for shift_add_multiplier. Two instances: WIDTH=4 for the
// directed handshake/boundary cases and WIDTH=8 for a back-to-back sweep.
// Drivers push the expected product when they issue a start; per-instance
// monitors pop and compare whenever done_o is seen.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // WIDTH = 4 instance
   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [7:0] bus4;
   logic       busy4, done4, zf4;

   // WIDTH = 8 instance
   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] bus8;
   logic        busy8, done8, zf8;

   shift_add_multiplier #(.WIDTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4),
      .bus_a_i(a4), .bus_b_i(b4),
      .bus_o(bus4), .busy_o(busy4), .done_o(done4), .flag_z_o(zf4)
   );

   shift_add_multiplier #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start8),
      .bus_a_i(a8), .bus_b_i(b8),
      .bus_o(bus8), .busy_o(busy8), .done_o(done8), .flag_z_o(zf8)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboards
   logic [7:0]  q4[$];
   logic [15:0] q8[$];

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Monitor for the WIDTH=4 instance
   always @(negedge clk) begin
      if (!rst && done4) begin
         if (q4.size() == 0) begin
            check("w4_unexpected_done", 1, 0);
         end else begin
            logic [7:0] e;
            e = q4.pop_front();
            check("w4_product", bus4, e);
            check("w4_zero_flag", zf4, (e == 0));
         end
      end
   end

   // Monitor for the WIDTH=8 instance, including done spacing
   int last_done8 = -1;
   always @(negedge clk) begin
      if (!rst && done8) begin
         if (q8.size() == 0) begin
            check("w8_unexpected_done", 1, 0);
         end else begin
            logic [15:0] e;
            e = q8.pop_front();
            check("w8_product", bus8, e);
         end
         if (last_done8 >= 0) check("w8_done_spacing", cyc - last_done8, 10);
         last_done8 = cyc;
      end
   end

   // One WIDTH=4 multiply with handshake timing checks.
   task automatic run4(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp);
      int n;
      int busy_n;
      @(negedge clk);
      a4 = a; b4 = b; start4 = 1'b1;
      q4.push_back(exp);
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      busy_n = 0;
      while (!done4 && n < 20) begin
         if (busy4) busy_n++;
         @(negedge clk);
         n++;
      end
      check("w4_busy_cycles", busy_n, 4);
      check("w4_done_latency", n, 4);
      @(negedge clk);
      check("w4_done_one_pulse", {busy4, done4}, 2'b00);
   endtask

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      check("rst_bus", bus4, 0);
      check("rst_busy_done", {busy4, done4}, 2'b00);
      check("rst_zero_flag", zf4, 1);
      rst = 1'b0;

      // Basic, carry on every add, zero operands
      run4(4'd3,  4'd5,  8'h0F);
      check("w4_hold_in_idle", bus4, 8'h0F);
      check("w4_flag_nonzero", zf4, 0);
      run4(4'd15, 4'd15, 8'hE1);
      run4(4'd0,  4'd9,  8'h00);
      run4(4'd7,  4'd0,  8'h00);

      // Operand changes and start pulses during RUN/DONE are ignored
      begin
         int n;
         int extra;
         @(negedge clk);
         a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
         q4.push_back(8'h06);
         @(negedge clk);
         a4 = 4'd15; b4 = 4'd15;          // first RUN cycle
         @(negedge clk);
         start4 = 1'b0;
         n = 0;
         while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("w4_ignore_done_seen", done4, 1);
         start4 = 1'b1;                   // pulse during DONE
         @(negedge clk);
         start4 = 1'b0;
         extra = 0;
         repeat (12) begin
            if (busy4 || done4) extra++;
            @(negedge clk);
         end
         check("w4_no_second_op", extra, 0);
         check("w4_ignore_hold", bus4, 8'h06);
      end

      // Reset in the middle of RUN
      @(negedge clk);
      a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
      @(negedge clk);                     // first RUN cycle
      start4 = 1'b0;
      @(negedge clk);                     // second RUN cycle
      rst = 1'b1;
      @(negedge clk);
      check("abort_bus", bus4, 0);
      check("abort_busy_done", {busy4, done4}, 2'b00);
      check("abort_zero_flag", zf4, 1);
      rst = 1'b0;
      last_done8 = -1;                    // reset also hit the WIDTH=8 unit
      run4(4'd6, 4'd7, 8'h2A);

      // WIDTH=8 back-to-back sweep; corners first
      for (int i = 0; i < 500; i++) begin
         logic [7:0] a;
         logic [7:0] b;
         int n;
         if (i == 0) begin
            a = 8'd255; b = 8'd255;
         end else if (i == 1) begin
            a = 8'd0; b = 8'd200;
         end else begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
         end
         @(negedge clk);                  // first IDLE cycle after DONE
         a8 = a; b8 = b; start8 = 1'b1;
         q8.push_back(16'(a) * 16'(b));
         @(negedge clk);
         start8 = 1'b0;
         n = 0;
         while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (!done8) begin
            check("w8_done_timeout", 0, 1);
            break;
         end
      end

      repeat (4) @(negedge clk);
      check("w4_queue_drained", q4.size(), 0);
      check("w8_queue_drained", q8.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
